// File: rtl/gpio_pattern_sequencer_if.sv
// ---------------------------------------------------------------------------
// gpio_pattern_sequencer_if
// Push-side handshake bundle for the GPIO pattern sequencer FIFO.
//   push_valid  master->slave  an entry is offered this cycle
//   push_ready  slave->master  the FIFO accepts an entry this cycle
//   push_data   master->slave  output pattern (PINS bits)
//   push_hold   master->slave  extra hold cycles (CNTW bits)
// An entry is transferred on every cycle with push_valid & push_ready.
// ---------------------------------------------------------------------------
interface gpio_pattern_sequencer_if #(
   parameter int PINS = 16,
   parameter int CNTW = 16
);
   logic            push_valid;
   logic            push_ready;
   logic [PINS-1:0] push_data;
   logic [CNTW-1:0] push_hold;

   modport master (output push_valid, output push_data, output push_hold, input push_ready);
   modport slave  (input push_valid, input push_data, input push_hold, output push_ready);
endinterface

// File: rtl/gpio_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// gpio_pattern_sequencer
// Timed output-pattern engine for the GPIO block. Software pushes
// {pattern, hold} entries into a FIFO; on start the FIFO is played out on
// seq_dout, each entry visible for hold+1 cycles, with no gap between entries.
//
// Ports:
//   HCLK, HRESET   clock, synchronous active-high reset
//   push_if        push handshake (valid/ready/data/hold), slave side
//   start, stop    1-cycle pulses: begin / abort playback
//   flush          empty the FIFO and force IDLE (any state)
//   irq_clr        clear the sticky irq flag
//   loop           (GPIO_SEQ_LOOP_EN only) repeat the sequence, sampled on start
//   busy, seq_oe   high while playing; seq_oe selects seq_dout in the DOUT mux
//   done           1-cycle pulse in the last cycle of a normal run
//   irq            sticky done flag
//   level          FIFO occupancy
//   seq_dout       current pattern (holds last value in IDLE)
//
// Build option: define GPIO_SEQ_LOOP_EN to add the loop port and loop mode.
// ---------------------------------------------------------------------------
module gpio_pattern_sequencer #(
   parameter int PINS  = 16,
   parameter int DEPTH = 8,
   parameter int CNTW  = 16
) (
   input  logic                       HCLK,
   input  logic                       HRESET,
   gpio_pattern_sequencer_if.slave    push_if,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       flush,
   input  logic                       irq_clr,
`ifdef GPIO_SEQ_LOOP_EN
   input  logic                       loop,
`endif
   output logic                       busy,
   output logic                       done,
   output logic                       irq,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic [PINS-1:0]            seq_dout,
   output logic                       seq_oe
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam int EW = PINS + CNTW;

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [PINS-1:0] dout_q, dout_d;
   logic            loop_q, loop_d;
   logic            irq_q, irq_d;
   logic [EW-1:0]   mem_q [DEPTH];

   logic            loop_in;
   logic            loop_eff;
   logic            full;
   logic            push_fire;
   logic            pop;
   logic            rewrite;
   logic [AW-1:0]   push_idx;
   logic [EW-1:0]   head;

`ifdef GPIO_SEQ_LOOP_EN
   assign loop_in = loop;
`else
   assign loop_in = 1'b0;
`endif

   assign full              = (level_q == LW'(DEPTH));
   assign push_if.push_ready = !full && !(loop_q && (state_q == RUN));
   assign push_fire         = push_if.push_valid && push_if.push_ready && !flush;
   assign head              = mem_q[rd_ptr_q];

   // Next-state logic. Pops only ever use the registered level, so an entry
   // pushed this cycle cannot be popped in the same cycle. In loop mode the
   // popped entry is written back at the tail; when that coincides with a
   // push (only possible on the start cycle) the push lands one slot later.
   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      loop_d   = loop_q;
      pop      = 1'b0;
      done     = 1'b0;
      loop_eff = loop_q;

      case (state_q)
         IDLE: begin
            if (!flush && start && (level_q != '0)) begin
               state_d  = RUN;
               pop      = 1'b1;
               loop_d   = loop_in;
               loop_eff = loop_in;
            end
         end
         RUN: begin
            if (flush || stop) begin
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNTW'(1);
            end else if (level_q != '0) begin
               pop = 1'b1;
            end else begin
               state_d = IDLE;
               done    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      rewrite  = pop && loop_eff;
      push_idx = wr_ptr_q + AW'(rewrite);

      if (pop) begin
         dout_d   = head[EW-1:CNTW];
         cnt_d    = head[CNTW-1:0];
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      wr_ptr_d = wr_ptr_q + AW'(rewrite) + AW'(push_fire);
      level_d  = level_q + LW'(push_fire) - LW'(pop && !rewrite);

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         level_d  = '0;
      end

      // A done in the same cycle as irq_clr keeps the flag set.
      irq_d = done || (irq_q && !irq_clr);
   end

   // Control and datapath registers.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q  <= IDLE;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
         loop_q   <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         loop_q   <= loop_d;
         irq_q    <= irq_d;
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge HCLK) begin
      if (rewrite) begin
         mem_q[wr_ptr_q] <= head;
      end
      if (push_fire) begin
         mem_q[push_idx] <= {push_if.push_data, push_if.push_hold};
      end
   end

   assign busy     = (state_q == RUN);
   assign seq_oe   = busy;
   assign irq      = irq_q;
   assign level    = level_q;
   assign seq_dout = dout_q;

endmodule
